// File: rtl/universal_shift_sequencer_if.sv
// Request/result bundle for the universal shift sequencer.
// master drives the operation request; slave returns register state and status.
interface universal_shift_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
);
  logic             start;
  logic [2:0]       mode;
  logic [AW-1:0]    amount;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             sout_l;
  logic             sout_r;

  modport master (
    output start, mode, amount, d, ser_in,
    input  q, busy, done, sout_l, sout_r
  );

  modport slave (
    input  start, mode, amount, d, ser_in,
    output q, busy, done, sout_l, sout_r
  );
endinterface

// File: rtl/universal_shift_sequencer.sv
// Multi-step shift/rotate/load register: an accepted request is executed as a
// sequence of single-bit steps, one per clock, followed by a one-cycle done pulse.
module universal_shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned INIT  = 1,
  parameter int unsigned AW    = 4
) (
  input logic                      clk,
  input logic                      rst,
  universal_shift_sequencer_if.slave bus
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ROL  = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_LOAD = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_RSVD = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [2:0]       op_mode;
  logic [AW-1:0]    count;
  logic             op_ser;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             sout_l;
  logic             sout_r;

  logic [WIDTH-1:0] step_q;
  logic             step_sl;
  logic             step_sr;

  assign bus.q      = q;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.sout_l = sout_l;
  assign bus.sout_r = sout_r;

  // Result of applying one step of the latched operation to the current register.
  always_comb begin
    step_q  = q;
    step_sl = sout_l;
    step_sr = sout_r;
    case (op_mode)
      M_SHL: begin
        step_q  = {q[WIDTH-2:0], op_ser};
        step_sl = q[WIDTH-1];
      end
      M_SHR: begin
        step_q  = {op_ser, q[WIDTH-1:1]};
        step_sr = q[0];
      end
      M_ROL: begin
        step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        step_sl = q[WIDTH-1];
      end
      M_ROR: begin
        step_q  = {q[0], q[WIDTH-1:1]};
        step_sr = q[0];
      end
      M_ASR: begin
        step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        step_sr = q[0];
      end
      M_LOAD:  step_q = op_d;
      default: step_q = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_mode <= M_HOLD;
      count   <= '0;
      op_ser  <= 1'b0;
      op_d    <= '0;
      q       <= WIDTH'(INIT);
      busy    <= 1'b0;
      done    <= 1'b0;
      sout_l  <= 1'b0;
      sout_r  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          q      <= step_q;
          sout_l <= step_sl;
          sout_r <= step_sr;
          count  <= count - AW'(1);
          if (count == AW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a request, allowing back-to-back operations.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (bus.start) begin
            op_mode <= bus.mode;
            op_ser  <= bus.ser_in;
            op_d    <= bus.d;
            if (bus.mode == M_LOAD) begin
              count <= AW'(1);
              state <= RUN;
              busy  <= 1'b1;
            end else if (bus.mode == M_HOLD || bus.mode == M_RSVD || bus.amount == '0) begin
              count <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              count <= bus.amount;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_sequencer.sv
// Directed bench for universal_shift_sequencer (WIDTH=8, INIT=1, AW=4):
// a chained vector table plus hand sequences for latency, back-to-back, ignore and abort.
module tb_universal_shift_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  universal_shift_sequencer_if #(.WIDTH(8), .AW(4)) bus ();

  universal_shift_sequencer #(.WIDTH(8), .INIT(1), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] d;
    logic       ser;
    logic [7:0] q;
    logic       sl;
    logic       sr;
    int         busy_cycles;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and count busy cycles; request inputs are scrambled after acceptance.
  task automatic do_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] dd,
                       input logic s, output int bc);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.amount = a;
    bus.d      = dd;
    bus.ser_in = s;
    tick();
    bus.start  = 1'b0;
    bus.mode   = 3'd5;
    bus.amount = 4'hF;
    bus.ser_in = ~s;
    bc = 0;
    while (bus.busy === 1'b1 && bc < 40) begin
      bc++;
      tick();
    end
  endtask

  initial begin
    int bc;
    int activity;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{3'd4, 4'd1,  8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1};
    vecs[1]  = '{3'd5, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'd6, 4'd2,  8'h00, 1'b0, 8'hE9, 1'b0, 1'b0, 2};
    vecs[3]  = '{3'd5, 4'd7,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd1, 4'd10, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 10};
    vecs[5]  = '{3'd1, 4'd0,  8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vecs[6]  = '{3'd0, 4'd5,  8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vecs[7]  = '{3'd7, 4'd3,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 0};
    vecs[8]  = '{3'd2, 4'd3,  8'h00, 1'b0, 8'h1F, 1'b1, 1'b1, 3};
    vecs[9]  = '{3'd3, 4'd9,  8'h00, 1'b0, 8'h3E, 1'b0, 1'b1, 9};
    vecs[10] = '{3'd4, 4'd2,  8'h00, 1'b0, 8'h8F, 1'b0, 1'b1, 2};
    vecs[11] = '{3'd6, 4'd15, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 15};
    vecs[12] = '{3'd2, 4'd15, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 15};
    vecs[13] = '{3'd5, 4'd0,  8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 1};
    vecs[14] = '{3'd1, 4'd1,  8'h00, 1'b0, 8'hB4, 1'b0, 1'b0, 1};
    vecs[15] = '{3'd1, 4'd1,  8'h00, 1'b0, 8'h68, 1'b1, 1'b0, 1};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = 3'd0;
    bus.amount = 4'd0;
    bus.d      = 8'h00;
    bus.ser_in = 1'b0;

    // Reset state before any clock edge
    #1;
    chk("rst_q", 32'(bus.q), 32'h01);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sl", 32'(bus.sout_l), 32'd0);
    chk("rst_sr", 32'(bus.sout_r), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Rotate left by 3, per-edge latency, then back-to-back request during done
    bus.start = 1'b1; bus.mode = 3'd3; bus.amount = 4'd3;
    tick();
    bus.start = 1'b0; bus.mode = 3'd0; bus.amount = 4'd0;
    chk("rol_e0_busy", 32'(bus.busy), 32'd1);
    chk("rol_e0_q", 32'(bus.q), 32'h01);
    tick();
    chk("rol_e1_q", 32'(bus.q), 32'h02);
    tick();
    chk("rol_e2_q", 32'(bus.q), 32'h04);
    chk("rol_e2_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("rol_e3_q", 32'(bus.q), 32'h08);
    chk("rol_e3_busy", 32'(bus.busy), 32'd0);
    chk("rol_e3_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.mode = 3'd4; bus.amount = 4'd1;
    tick();
    bus.start = 1'b0; bus.mode = 3'd0; bus.amount = 4'd0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done", 32'(bus.done), 32'd0);
    tick();
    chk("b2b_q", 32'(bus.q), 32'h04);
    chk("b2b_done2", 32'(bus.done), 32'd1);
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Re-initialise to q=01 for the chained vector table
    rst = 1'b1;
    #1;
    chk("rst2_q", 32'(bus.q), 32'h01);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].mode, vecs[i].amount, vecs[i].d, vecs[i].ser, bc);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].busy_cycles));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
      chk($sformatf("v%0d_q", i), 32'(bus.q), 32'(vecs[i].q));
      chk($sformatf("v%0d_sout_l", i), 32'(bus.sout_l), 32'(vecs[i].sl));
      chk($sformatf("v%0d_sout_r", i), 32'(bus.sout_r), 32'(vecs[i].sr));
    end
    bus.mode = 3'd0;
    tick();
    chk("post_table_done", 32'(bus.done), 32'd0);

    // Start held high while busy must be ignored (q=68, rotate left 4)
    bus.start = 1'b1; bus.mode = 3'd3; bus.amount = 4'd4;
    tick();
    bus.mode = 3'd5; bus.d = 8'h00; bus.amount = 4'd1;
    tick();
    chk("ign_e1_q", 32'(bus.q), 32'hD0);
    tick();
    chk("ign_e2_q", 32'(bus.q), 32'hA1);
    tick();
    chk("ign_e3_q", 32'(bus.q), 32'h43);
    bus.start = 1'b0;
    tick();
    chk("ign_e4_q", 32'(bus.q), 32'h86);
    chk("ign_e4_done", 32'(bus.done), 32'd1);
    tick();
    chk("ign_after_q", 32'(bus.q), 32'h86);
    chk("ign_after_busy", 32'(bus.busy), 32'd0);

    // Reset pulse at step 2 of a 5-step shift aborts with no done
    bus.start = 1'b1; bus.mode = 3'd1; bus.amount = 4'd5; bus.ser_in = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_pre_q", 32'(bus.q), 32'h18);
    rst = 1'b1;
    #1;
    chk("abort_q", 32'(bus.q), 32'h01);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sl", 32'(bus.sout_l), 32'd0);
    bus.start = 1'b1;
    tick();
    chk("abort_rst_start_q", 32'(bus.q), 32'h01);
    chk("abort_rst_start_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    activity = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) activity++;
    end
    chk("abort_no_done", 32'(activity), 32'd0);
    chk("abort_final_q", 32'(bus.q), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_sequencer.md
UNIVERSAL_SHIFT_SEQUENCER -- requirements
Module: universal_shift_sequencer

Parameters
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=2).
REQ-002 SHALL have parameter INIT, default 1 (zero-extended to WIDTH), reset value of q.
REQ-003 SHALL have parameter AW, default 4, width of amount port.

Interface
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request; sampled on posedge clk only while busy=0.
REQ-007 mode  in  3  operation: 000 hold, 001 shift left, 010 shift right logical, 011 rotate left, 100 rotate right, 101 parallel load, 110 arithmetic shift right, 111 reserved (treated as hold).
REQ-008 amount  in  AW  number of single-bit steps; ignored for load, hold and reserved.
REQ-009 d  in  WIDTH  parallel load data.
REQ-010 ser_in  in  1  fill bit: enters LSB on shift left, MSB on shift right logical.
REQ-011 q  out  WIDTH  register contents, registered.
REQ-012 busy  out  1  high while steps remain.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 sout_l  out  1  bit most recently leaving the MSB.
REQ-015 sout_r  out  1  bit most recently leaving the LSB.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-017 In IDLE or DONE, start=1 at an edge SHALL latch mode, amount and ser_in into internal op registers; later changes to these inputs SHALL NOT affect the operation.
REQ-018 On acceptance: load → next state RUN with step count 1; hold/reserved or amount=0 → DONE with q unchanged; otherwise → RUN with step count amount.
REQ-019 In RUN, each edge SHALL apply exactly one single-bit step of the latched mode and decrement the count; the edge applying the last step SHALL enter DONE.
REQ-020 Latency: start accepted at edge 0, steps at edges 1..N, done high for the cycle after edge N, busy high from after edge 0 until edge N.
REQ-021 DONE without start SHALL return to IDLE after one cycle; DONE with start SHALL accept it (back-to-back ops, no idle cycle).
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 Shift left: q <= {q[WIDTH-2:0], ser_in}; sout_l <= old q[WIDTH-1].
REQ-024 Shift right logical: q <= {ser_in, q[WIDTH-1:1]}; sout_r <= old q[0].
REQ-025 Rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout_l <= old MSB. Rotate right: q <= {q[0], q[WIDTH-1:1]}; sout_r <= old LSB.
REQ-026 Arithmetic shift right: MSB replicated; sout_r <= old LSB.
REQ-027 Load: q <= d in one step; sout_l/sout_r unchanged.
REQ-028 amount > WIDTH SHALL be legal: shifts fully flush to fill value, rotates wrap modulo WIDTH by stepping.
REQ-029 sout_l/sout_r SHALL hold their value when no step of the corresponding direction occurs.

Reset
REQ-030 rst=1 SHALL immediately, without clock, force q=INIT, busy=0, done=0, sout_l=0, sout_r=0, state IDLE, count 0, op registers cleared.
REQ-031 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow; start is ignored while rst=1.

Verification (WIDTH=8, INIT=1, AW=4)
REQ-032 Assert rst → q=8'h01, busy=0, done=0, sout_l=sout_r=0 before any clock edge.
REQ-033 start, rotate left, amount=3 → q 8'h02,8'h04,8'h08 on edges 1-3; busy 3 cycles; done 1 cycle; next start accepted during done.
REQ-034 From 8'h01, rotate right amount=1 → q=8'h80, sout_r=1, done after 1 step.
REQ-035 Load d=8'hA5, then ASR amount=2 → q=8'hE9, sout_r=0; load causes exactly 1 busy cycle.
REQ-036 Load 8'h00, shift left ser_in=1 amount=10 → q=8'hFF after 10 steps, sout_l=1; amount=0 → done next cycle, q unchanged, busy never high.
REQ-037 start during busy ignored (q matches original op only); rst pulse at step 2 of 5 → q=8'h01 immediately, busy=0, no done.
